sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
//   Arbitrates NCH sram-like masters onto one sram-like slave. The address
//   phase is granted per channel; each accepted address pushes the channel id
//   into an in-order ID FIFO. Each slave data response pops the FIFO and is
//   routed back to the channel that issued it. Once a request has been shown to
//   the slave without acceptance, the grant is locked until it is accepted.
//
//   Optional feature: define SRAM_ARB_RR_EN for round-robin selection.
//   Without it, selection is fixed priority (lowest index wins).
//
//   Ports
//     clk, resetn                     clock, async active-low reset
//     m_req/m_wr/m_size/m_wstrb/...   master request side, channel i = slice i
//     m_addr_ok, m_data_ok, m_rdata   master response side (m_rdata shared)
//     s_req/s_wr/s_size/s_wstrb/...   slave request side
//     s_addr_ok, s_data_ok, s_rdata   slave response side
//     err_orphan                      sticky: data response with none outstanding
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | grant follows the selector over pending channels
//   LOCK  | request shown but not accepted; grant frozen on r_lock_id
// ---------------------------------------------------------------------------
module sram_like_arbiter #(
  parameter int NCH   = 2,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NCH-1:0]      m_req,
  input  logic [NCH-1:0]      m_wr,
  input  logic [2*NCH-1:0]    m_size,
  input  logic [4*NCH-1:0]    m_wstrb,
  input  logic [32*NCH-1:0]   m_addr,
  input  logic [32*NCH-1:0]   m_wdata,
  output logic [NCH-1:0]      m_addr_ok,
  output logic [NCH-1:0]      m_data_ok,
  output logic [31:0]         m_rdata,
  output logic                s_req,
  output logic                s_wr,
  output logic [1:0]          s_size,
  output logic [3:0]          s_wstrb,
  output logic [31:0]         s_addr,
  output logic [31:0]         s_wdata,
  input  logic                s_addr_ok,
  input  logic                s_data_ok,
  input  logic [31:0]         s_rdata,
  output logic                err_orphan
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_lock_id;
  logic [IDW-1:0]   r_fifo [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic             r_err_orphan;
`ifdef SRAM_ARB_RR_EN
  logic [IDW-1:0]   r_rr_ptr;
`endif

  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_grant;
  logic             w_pending;
  logic             w_full;
  logic             w_empty;
  logic             w_hs;
  logic             w_pop;
  logic [IDW-1:0]   w_head_id;

  // Selection among pending channels (used only in IDLE).
`ifdef SRAM_ARB_RR_EN
  always_comb begin
    int idx;
    idx   = 0;
    w_sel = '0;
    // Walk backwards so the last hit is the first pending at/after r_rr_ptr.
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NCH;
      if (m_req[idx]) w_sel = IDW'(idx);
    end
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m_req[i]) w_sel = IDW'(i);
    end
  end
`endif

  assign w_grant   = (r_state == ST_LOCK) ? r_lock_id : w_sel;
  assign w_pending = m_req[w_grant];
  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);

  // resetn gates s_req so every master-visible strobe is quiet during reset.
  assign s_req     = resetn & w_pending & ~w_full;
  assign w_hs      = s_req & s_addr_ok;
  assign w_pop     = s_data_ok & ~w_empty;
  assign w_head_id = r_fifo[r_head];
  assign m_rdata   = s_rdata;
  assign err_orphan = r_err_orphan;

  always_comb begin
    s_wr      = 1'b0;
    s_size    = '0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == IDW'(i)) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_wstrb = m_wstrb[4*i +: 4];
        s_addr  = m_addr[32*i +: 32];
        s_wdata = m_wdata[32*i +: 32];
      end
      m_addr_ok[i] = w_hs  && (w_grant   == IDW'(i));
      m_data_ok[i] = w_pop && (w_head_id == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_lock_id    <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
`ifdef SRAM_ARB_RR_EN
      r_rr_ptr     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_req && !s_addr_ok) begin
            r_state   <= ST_LOCK;
            r_lock_id <= w_grant;
          end
        end
        ST_LOCK: begin
          if (w_hs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_hs) begin
        r_fifo[r_tail] <= w_grant;
        r_tail         <= r_tail + PW'(1);
`ifdef SRAM_ARB_RR_EN
        r_rr_ptr <= (w_grant == IDW'(NCH - 1)) ? '0 : w_grant + IDW'(1);
`endif
      end
      if (w_pop) r_head <= r_head + PW'(1);

      // Push is impossible while full, so push+pop never overflows the count.
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase

      if (s_data_ok && w_empty) r_err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  localparam int NCH   = 3;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                resetn;
  logic [NCH-1:0]      m_req;
  logic [NCH-1:0]      m_wr;
  logic [2*NCH-1:0]    m_size;
  logic [4*NCH-1:0]    m_wstrb;
  logic [32*NCH-1:0]   m_addr;
  logic [32*NCH-1:0]   m_wdata;
  logic [NCH-1:0]      m_addr_ok;
  logic [NCH-1:0]      m_data_ok;
  logic [31:0]         m_rdata;
  logic                s_req;
  logic                s_wr;
  logic [1:0]          s_size;
  logic [3:0]          s_wstrb;
  logic [31:0]         s_addr;
  logic [31:0]         s_wdata;
  logic                s_addr_ok;
  logic                s_data_ok;
  logic [31:0]         s_rdata;
  logic                err_orphan;

  sram_like_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: locked channel (-1 = none), queue of outstanding ids,
  // round-robin pointer, sticky orphan flag.
  int lock_ch;
  int q[$];
  int rr;
  bit err;
  logic [NCH-1:0] last_aok;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    lock_ch = -1;
    rr = 0;
    err = 1'b0;
    last_aok = '0;
  endfunction

  function automatic int pick();
`ifdef SRAM_ARB_RR_EN
    for (int k = 0; k < NCH; k++) if (m_req[(rr + k) % NCH]) return (rr + k) % NCH;
`else
    for (int i = 0; i < NCH; i++) if (m_req[i]) return i;
`endif
    return 0;
  endfunction

  task automatic set_req(int ch, logic [31:0] a);
    m_req[ch]           = 1'b1;
    m_wr[ch]            = 1'($urandom_range(0, 1));
    m_size[2*ch +: 2]   = 2'($urandom_range(0, 3));
    m_wstrb[4*ch +: 4]  = 4'($urandom_range(0, 15));
    m_addr[32*ch +: 32] = a;
    m_wdata[32*ch +: 32] = $urandom;
  endtask

  // Called at posedge+1 with inputs driven; checks at the falling edge,
  // advances the model, and returns at the next posedge+1.
  task automatic step();
    int g;
    bit exp_req, hs, pop;
    logic [NCH-1:0] exp_aok, exp_dok;
    #4;
    g = (lock_ch >= 0) ? lock_ch : pick();
    exp_req = m_req[g] && (q.size() < DEPTH);
    hs  = exp_req && s_addr_ok;
    pop = s_data_ok && (q.size() > 0);
    exp_aok = hs  ? (NCH'(1) << g)    : '0;
    exp_dok = pop ? (NCH'(1) << q[0]) : '0;
    check("s_req", s_req, exp_req);
    check("m_addr_ok", m_addr_ok, exp_aok);
    check("m_data_ok", m_data_ok, exp_dok);
    check("m_rdata", m_rdata, s_rdata);
    check("err_orphan", err_orphan, err);
    if (exp_req) begin
      check("s_addr", s_addr, m_addr[32*g +: 32]);
      check("s_wdata", s_wdata, m_wdata[32*g +: 32]);
      check("s_wr", s_wr, m_wr[g]);
      check("s_size", s_size, m_size[2*g +: 2]);
      check("s_wstrb", s_wstrb, m_wstrb[4*g +: 4]);
    end
    if (s_data_ok && q.size() == 0) err = 1'b1;
    if (pop) void'(q.pop_front());
    if (hs) begin
      q.push_back(g);
      rr = (g + 1) % NCH;
    end
    if (lock_ch < 0 && exp_req && !s_addr_ok) lock_ch = g;
    else if (lock_ch >= 0 && hs) lock_ch = -1;
    last_aok = exp_aok;
    @(posedge clk);
    #1;
  endtask

  task automatic random_cycles(int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (last_aok[i]) m_req[i] = 1'b0;
        if (!m_req[i] && $urandom_range(0, 2) == 0) set_req(i, $urandom);
      end
      s_addr_ok = ($urandom_range(0, 3) != 0);
      s_data_ok = ($urandom_range(0, 2) == 0);
      s_rdata   = $urandom;
      step();
    end
  endtask

  initial begin
    resetn = 1'b0;
    m_req = '1; m_wr = '0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
    model_reset();
    #2;
    check("rst_s_req", s_req, 1'b0);
    check("rst_m_addr_ok", m_addr_ok, '0);
    check("rst_m_data_ok", m_data_ok, '0);
    check("rst_err_orphan", err_orphan, 1'b0);
    @(posedge clk); #1;
    m_req = '0; s_data_ok = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // First cycle after reset: ch0 @0x100 and ch1 @0x200, then responses.
    set_req(0, 32'h100);
    set_req(1, 32'h200);
    s_addr_ok = 1'b1;
    step();
    check("first_hs_ch0", last_aok, 3'b001);
    m_req[0] = 1'b0;
    step();
    check("second_hs_ch1", last_aok, 3'b010);
    m_req = '0;
    s_data_ok = 1'b1; s_rdata = 32'hAAAA_0000;
    step();
    s_rdata = 32'hBBBB_0000;
    step();
    s_data_ok = 1'b0;

    // Lock: ch1 waits 3 cycles unaccepted, ch0 joins in cycle 2.
    set_req(1, 32'h300);
    s_addr_ok = 1'b0;
    step();
    set_req(0, 32'h400);
    step();
    step();
    s_addr_ok = 1'b1;
    step();
    check("lock_hs_ch1", last_aok, 3'b010);
    m_req[1] = 1'b0;
    step();
    check("after_lock_ch0", last_aok, 3'b001);
    m_req = '0;
    s_data_ok = 1'b1;
    step();
    step();

    // Fill the FIFO: 4 accepted, 5th blocked until a pop, then accepted.
    s_data_ok = 1'b0;
    set_req(2, 32'h500);
    for (int i = 0; i < 5; i++) step();
    check("full_blocks", last_aok, '0);
    s_data_ok = 1'b1;
    step();
    s_data_ok = 1'b0;
    step();
    check("fifth_hs", last_aok, 3'b100);
    m_req = '0;
    s_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Orphan response: FIFO now empty.
    step();
    s_data_ok = 1'b0;
    step();
    check("orphan_sticky", err_orphan, 1'b1);

    random_cycles(400);

    // Reset with two outstanding and the grant locked.
    m_req = '0; s_data_ok = 1'b0; s_addr_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data_ok = (q.size() > 0);
      step();
    end
    s_data_ok = 1'b0;
    set_req(0, 32'h600);
    step();
    step();
    m_req[0] = 1'b0;
    set_req(1, 32'h700);
    s_addr_ok = 1'b0;
    step();
    check("pre_rst_locked", lock_ch, 1);
    check("pre_rst_outstanding", q.size(), 2);
    resetn = 1'b0;
    s_addr_ok = 1'b1; s_data_ok = 1'b1;
    #1;
    check("midrst_s_req", s_req, 1'b0);
    check("midrst_m_addr_ok", m_addr_ok, '0);
    check("midrst_m_data_ok", m_data_ok, '0);
    check("midrst_err", err_orphan, 1'b0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    s_data_ok = 1'b0;
    set_req(0, 32'h800);
    m_req[1] = 1'b0;
    step();
    check("post_rst_hs", last_aok, 3'b001);
    m_req = '0;
    s_data_ok = 1'b1;
    step();
    s_data_ok = 1'b0;
    step();
    check("post_rst_no_orphan", err_orphan, 1'b0);

    random_cycles(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
